// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, odd-parity helper and
// 50 MHz default timing constants, common to the PS/2 transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        REQ     = 3'd2,
        SHIFT   = 3'd3,
        ACK     = 3'd4
    } ps2_state_e;

    localparam int PS2_INHIBIT_CYCLES_50M = 5000;
    localparam int PS2_TIMEOUT_CYCLES_50M = 750000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_edge.sv
// Falling-edge strobe for the filtered PS/2 clock line.
module ps2_clk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    output logic fall
);

    logic clk_q;

    // Previous line level; resets high (idle bus) so a released line never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q <= 1'b1;
        end else begin
            clk_q <= ps2_clk_in;
        end
    end

    assign fall = clk_q & ~ps2_clk_in;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit odd-parity frame,
// device acknowledge check and a clock-release-to-ack timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_50M,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_50M
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_ONE  = IW'(1'b1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1'b1);

    ps2_state_e    state_r, state_s;
    logic [IW-1:0] inh_cnt_r, inh_cnt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_s;
    logic [3:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    data_r, data_s;
    logic          clk_oe_r, clk_oe_s;
    logic          data_oe_r, data_oe_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          err_r, err_s;
    logic          fall_s;
    logic          bit_val_s;
    logic          to_hit_s;

    ps2_clk_edge u_clk_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_in (ps2_clk_in),
        .fall       (fall_s)
    );

    assign to_hit_s = (to_cnt_r == TO_LAST);

    // Level of the bit launched by the current falling edge: data LSB first, parity, stop.
    always_comb begin
        bit_val_s = 1'b1;
        case (bit_idx_r)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: bit_val_s = data_r[bit_idx_r[2:0]];
            4'd8:                   bit_val_s = odd_parity(data_r);
            default:                bit_val_s = 1'b1;
        endcase
    end

    // Next-state and next-output logic; the timeout has priority over a clock edge.
    always_comb begin
        state_s   = state_r;
        inh_cnt_s = inh_cnt_r;
        to_cnt_s  = to_cnt_r;
        bit_idx_s = bit_idx_r;
        data_s    = data_r;
        clk_oe_s  = 1'b0;
        data_oe_s = data_oe_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                data_oe_s = 1'b0;
                // A request in the cycle done/err pulses is dropped, not held over.
                if (tx_start && !done_r && !err_r) begin
                    data_s    = tx_data;
                    busy_s    = 1'b1;
                    clk_oe_s  = 1'b1;
                    inh_cnt_s = {IW{1'b0}};
                    state_s   = INHIBIT;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            INHIBIT: begin
                clk_oe_s = 1'b1;
                if (inh_cnt_r == INH_LAST) begin
                    data_oe_s = 1'b1;
                    state_s   = REQ;
                end else begin
                    inh_cnt_s = inh_cnt_r + INH_ONE;
                end
            end
            REQ: begin
                data_oe_s = 1'b1;
                to_cnt_s  = {TW{1'b0}};
                bit_idx_s = 4'd0;
                state_s   = SHIFT;
            end
            SHIFT: begin
                to_cnt_s = to_cnt_r + TO_ONE;
                if (to_hit_s) begin
                    data_oe_s = 1'b0;
                    busy_s    = 1'b0;
                    err_s     = 1'b1;
                    state_s   = IDLE;
                end else if (fall_s) begin
                    data_oe_s = ~bit_val_s;
                    bit_idx_s = bit_idx_r + 4'd1;
                    state_s   = (bit_idx_r == 4'd9) ? ACK : SHIFT;
                end else begin
                    state_s   = SHIFT;
                end
            end
            ACK: begin
                data_oe_s = 1'b0;
                to_cnt_s  = to_cnt_r + TO_ONE;
                if (to_hit_s) begin
                    busy_s  = 1'b0;
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (fall_s) begin
                    busy_s  = 1'b0;
                    done_s  = ~ps2_data_in;
                    err_s   = ps2_data_in;
                    state_s = IDLE;
                end else begin
                    state_s = ACK;
                end
            end
            default: begin
                data_oe_s = 1'b0;
                busy_s    = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State, counters and registered pad/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            inh_cnt_r <= {IW{1'b0}};
            to_cnt_r  <= {TW{1'b0}};
            bit_idx_r <= 4'd0;
            data_r    <= 8'h00;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            inh_cnt_r <= inh_cnt_s;
            to_cnt_r  <= to_cnt_s;
            bit_idx_r <= bit_idx_s;
            data_r    <= data_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule
